// File: rtl/cm0_rst_recv_seq_if.sv
// Reset request handshake between a sender domain and the receive-side sequencer.
// The master is the sender; the slave is cm0_rst_recv_seq.
interface cm0_rst_recv_seq_if;
  logic RSTREQIN;
  logic RSTOUT;
  logic RSTACK;
  logic RSTSYNC;

  modport master (output RSTREQIN, input RSTOUT, RSTACK, RSTSYNC);
  modport slave  (input RSTREQIN, output RSTOUT, RSTACK, RSTSYNC);
endinterface

// File: rtl/cm0_rst_recv_seq.sv
// Receive-side reset sequencer: synchronises RSTREQIN, then drives a glitch-free
// downstream reset with minimum hold, four-phase acknowledge and release delay.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no reset; RSTOUT=0 RSTACK=0; wait for synchronised request
// ST_ASSERT  | RSTOUT=1; hold for HOLD_CYCLES regardless of request level
// ST_WAITREL | RSTOUT=1 RSTACK=1; wait for sender to drop its request
// ST_RELEASE | RSTOUT=1; RELEASE_CYCLES delay, re-request returns to ST_ASSERT
module cm0_rst_recv_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int RELEASE_CYCLES = 4
) (
  input logic              CLK,
  input logic              RST,
  cm0_rst_recv_seq_if.slave rif
);

  localparam int CNT_MAX = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REL_TC  = CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_WAITREL = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sreq;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   rstout_q;
  logic                   rstack_q;

  // Plain flop chain, nothing between stages, so metastability has a full cycle per stage.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rif.RSTREQIN};
    end
  end

  assign sreq = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      rstout_q <= 1'b1;
      rstack_q <= 1'b0;
    end else begin
      if (cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (sreq) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            rstout_q <= 1'b1;
            rstack_q <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (cnt == HOLD_TC) begin
            state    <= ST_WAITREL;
            cnt      <= '0;
            rstack_q <= 1'b1;
          end
        end
        ST_WAITREL: begin
          if (!sreq) begin
            state    <= ST_RELEASE;
            cnt      <= '0;
            rstack_q <= 1'b0;
          end
        end
        ST_RELEASE: begin
          // A fresh request wins over the release terminal count so RSTOUT never dips.
          if (sreq) begin
            state <= ST_ASSERT;
            cnt   <= '0;
          end else if (cnt == REL_TC) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rstout_q <= 1'b0;
          end
        end
        default: begin
          state    <= ST_ASSERT;
          cnt      <= '0;
          rstout_q <= 1'b1;
          rstack_q <= 1'b0;
        end
      endcase
    end
  end

  assign rif.RSTOUT  = rstout_q;
  assign rif.RSTACK  = rstack_q;
  assign rif.RSTSYNC = sreq;

endmodule

// File: tb/tb_cm0_rst_recv_seq.sv
// Scoreboard bench: each stimulus step queues the expected {RSTOUT,RSTACK,RSTSYNC}
// per cycle; negedge monitors pop and compare for the default and swept instances.
module tb_cm0_rst_recv_seq;

  logic CLK = 1'b0;
  logic rst0;
  logic rst1;
  int   checks = 0;
  int   errors = 0;
  string phase = "init";

  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 CLK = ~CLK;

  cm0_rst_recv_seq_if ifc0 ();
  cm0_rst_recv_seq_if ifc1 ();

  cm0_rst_recv_seq u_dut0 (
    .CLK (CLK),
    .RST (rst0),
    .rif (ifc0)
  );

  cm0_rst_recv_seq #(
    .SYNC_STAGES    (4),
    .HOLD_CYCLES    (1),
    .RELEASE_CYCLES (1)
  ) u_dut1 (
    .CLK (CLK),
    .RST (rst1),
    .rif (ifc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    logic [2:0] e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk({phase, "/dut0"}, {29'd0, ifc0.RSTOUT, ifc0.RSTACK, ifc0.RSTSYNC}, {29'd0, e});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk({phase, "/dut1"}, {29'd0, ifc1.RSTOUT, ifc1.RSTACK, ifc1.RSTSYNC}, {29'd0, e});
    end
  end

  task automatic push(input int d, input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (d == 0) q0.push_back(v);
      else        q1.push_back(v);
    end
  endtask

  task automatic set_req(input int d, input logic v);
    if (d == 0) ifc0.RSTREQIN = v;
    else        ifc1.RSTREQIN = v;
  endtask

  // Returns two time units after the posedge that opens the first unscheduled cycle.
  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge CLK);
      #2;
      if (q0.size() == 0 && q1.size() == 0) done = 1;
    end
    if (!done) chk({phase, "/drain_timeout"}, q0.size() + q1.size(), 0);
  endtask

  // Reset just sampled high at the current cycle's edge: hold, one ack cycle, release.
  task automatic push_rst(input int d, input int h, input int r);
    push(d, 3'b100, h);
    push(d, 3'b110, 1);
    push(d, 3'b100, r);
    push(d, 3'b000, 2);
  endtask

  // Request raised in IDLE: S cycles of sync latency, one more for the FSM, then hold.
  task automatic req_rise(input int d, input int s, input int h, input int extra);
    set_req(d, 1'b1);
    push(d, 3'b000, s);
    push(d, 3'b001, 1);
    push(d, 3'b101, h);
    push(d, 3'b111, 1 + extra);
  endtask

  // Request dropped in WAITREL: ack falls once sync sees it, RSTOUT after the release delay.
  task automatic req_drop(input int d, input int s, input int r);
    set_req(d, 1'b0);
    push(d, 3'b111, s);
    push(d, 3'b110, 1);
    push(d, 3'b100, r);
    push(d, 3'b000, 2);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    ifc0.RSTREQIN = 1'b0;
    ifc1.RSTREQIN = 1'b0;
    repeat (3) @(posedge CLK);
    #2;

    phase = "reset_release";
    rst0 = 1'b0;
    rst1 = 1'b0;
    push_rst(0, 16, 4);
    push_rst(1, 1, 1);
    wait_drain();

    phase = "single_req";
    req_rise(0, 2, 16, 0);
    wait_drain();
    req_drop(0, 2, 4);
    wait_drain();

    phase = "long_hold";
    req_rise(0, 2, 16, 100);
    wait_drain();
    req_drop(0, 2, 4);
    wait_drain();

    phase = "re_request";
    req_rise(0, 2, 16, 0);
    wait_drain();
    set_req(0, 1'b0);
    push(0, 3'b111, 2);
    push(0, 3'b110, 1);
    push(0, 3'b100, 1);
    wait_drain();
    set_req(0, 1'b1);
    push(0, 3'b100, 2);
    push(0, 3'b101, 17);
    push(0, 3'b111, 1);
    wait_drain();
    req_drop(0, 2, 4);
    wait_drain();

    phase = "rst_mid_waitrel";
    req_rise(0, 2, 16, 0);
    wait_drain();
    rst0 = 1'b1;
    push(0, 3'b111, 1);
    push(0, 3'b100, 2);
    push(0, 3'b101, 14);
    push(0, 3'b111, 1);
    @(posedge CLK);
    #2;
    rst0 = 1'b0;
    wait_drain();
    req_drop(0, 2, 4);
    wait_drain();

    phase = "sweep_s4_h1_r1";
    req_rise(1, 4, 1, 0);
    wait_drain();
    req_drop(1, 4, 1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
